ranging_scheduler: RTL
======================

Name: ranging_scheduler

Overview:
Sequences the ultrasonic ranging front end. Issues the trig pulse, synchronises and times the echo return, applies timeouts, and enforces a holdoff between pings. Runs in single-shot or free-running mode. Delivers echo_cycles with a one-cycle valid strobe to set_reading, and sits between the sensor pins and the display/history datapath.

Parameters:
TRIG_CYCLES, 120, trig high time in clk cycles (10 us at 12 MHz)
RISE_TIMEOUT, 36000, max cycles from trig fall to echo rise before timeout (3 ms)
ECHO_MAX, 456000, echo width saturation/timeout in cycles (38 ms)
HOLDOFF_CYCLES, 720000, minimum cycles from measurement end to next trig (60 ms)
CNT_W, 32, width of echo_cycles and internal counters

Ports:
clk  in  1  system clock (12 MHz HFOSC domain)
rst  in  1  synchronous active-high reset
enable  in  1  free-running mode: re-ping continuously while high
start  in  1  single-shot request pulse; ignored while busy
echo  in  1  raw asynchronous echo from sensor
trig  out  1  trigger pulse to sensor, registered
busy  out  1  high in every state except IDLE
echo_cycles  out  CNT_W  last measured echo width; held between measurements
meas_valid  out  1  one-cycle strobe when echo_cycles updates
meas_timeout  out  1  one-cycle strobe on rise timeout or ECHO_MAX saturation
meas_count  out  16  completed-measurement counter

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (rst): on rst at an edge, state=IDLE, all counters=0, trig=0, busy=0, echo_cycles=0, meas_valid=0, meas_timeout=0, meas_count=0. Applies mid-measurement too; trig is low after that edge.
- echo passes through a 2-flop synchroniser (echo_s). Add 2 cycles of latency; all decisions use echo_s.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: start=1 or enable=1 at edge k -> TRIG. trig=1 for exactly TRIG_CYCLES cycles, starting at cycle k+1.
- TRIG: after TRIG_CYCLES cycles -> WAIT_RISE, and trig=0 that same cycle. echo_s is ignored during TRIG.
- WAIT_RISE: timer starts at 0 on entry.
  - echo_s=1 -> MEASURE, with width counter=1.
  - Timer reaching RISE_TIMEOUT with echo_s still 0 -> pulse meas_timeout, leave echo_cycles unchanged, meas_count++, -> HOLDOFF.
- MEASURE: each cycle with echo_s=1, width++.
  - echo_s=0 -> echo_cycles=width, pulse meas_valid, meas_count++, -> HOLDOFF. An echo_s high for N cycles yields echo_cycles=N.
  - width reaching ECHO_MAX -> echo_cycles=ECHO_MAX, pulse meas_valid and meas_timeout in the same cycle, meas_count++, -> HOLDOFF.
- HOLDOFF: timer starts at 0 on entry. Exit only when timer >= HOLDOFF_CYCLES AND echo_s=0; a stuck-high echo extends holdoff indefinitely. On exit:
  - enable=1 -> TRIG directly.
  - otherwise -> IDLE.
- start pulses arriving while busy=1 are dropped, not queued. If start and enable are both high in IDLE, one ping is issued.
- enable falling mid-measurement: the current measurement completes normally, then HOLDOFF -> IDLE.
- meas_count wraps 0xFFFF -> 0x0000.
- Counters saturate; they never wrap within a state.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Package ranging_pkg:
  - state enum typedef ranging_state_t {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF}
  - default timing constants derived from the 12 MHz clock
- Sub-module sync2: generic 2-flop synchroniser with synchronous active-high reset to 0. Instantiate it once for echo.

Test Plan:
All scenarios use TRIG_CYCLES=4, RISE_TIMEOUT=20, ECHO_MAX=50, HOLDOFF_CYCLES=10.
- Single shot: start pulse at cycle 0, echo high for 15 cycles beginning 3 cycles after trig falls -> trig high cycles 1-4, echo_cycles=15, one meas_valid, meas_count=1, busy drops after holdoff, no second trig.
- Rise timeout: start with echo held low -> meas_timeout pulse 20 cycles after WAIT_RISE entry, meas_valid never asserted, echo_cycles keeps its previous value, meas_count increments.
- Saturation: echo held high for 80 cycles -> echo_cycles=50, meas_valid and meas_timeout coincide. Holdoff does not end until echo_s has fallen and 10 cycles have elapsed.
- Free-running: enable=1 with 12-cycle echoes -> successive trig rising edges spaced exactly 4 + (wait) + 12 + 10 (+ sync latency) cycles apart. Drop enable mid-MEASURE -> that measurement completes, then IDLE.
- Start while busy: second start during MEASURE -> ignored, exactly one meas_valid.
- Reset mid-TRIG: rst at cycle 2 of trig -> next edge trig=0, busy=0, echo_cycles=0, meas_count=0. A start afterwards behaves as in the single-shot case.

Source files
------------

// File: rtl/ranging_pkg.sv
// Shared state encoding and default timing for the ultrasonic ranging scheduler.
// Defaults assume the 12 MHz HFOSC clock.
package ranging_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } ranging_state_t;

    localparam int CLK_HZ             = 12_000_000;
    localparam int DEF_TRIG_CYCLES    = CLK_HZ / 100_000;      // 10 us
    localparam int DEF_RISE_TIMEOUT   = CLK_HZ / 1000 * 3;     // 3 ms
    localparam int DEF_ECHO_MAX       = CLK_HZ / 1000 * 38;    // 38 ms
    localparam int DEF_HOLDOFF_CYCLES = CLK_HZ / 1000 * 60;    // 60 ms

endpackage

// File: rtl/ranging_scheduler_sync2.sv
// Generic two-flop synchroniser for bringing asynchronous inputs into the clk domain.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ranging_scheduler.sv
// Ultrasonic ranging sequencer: trig pulse, echo timing with timeouts, and
// a holdoff between pings, in single-shot or free-running mode.
module ranging_scheduler
    import ranging_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int RISE_TIMEOUT   = DEF_RISE_TIMEOUT,
    parameter int ECHO_MAX       = DEF_ECHO_MAX,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic [CNT_W-1:0] echo_cycles,
    output logic             meas_valid,
    output logic             meas_timeout,
    output logic [15:0]      meas_count
);

    // A phase ends on the edge where the counter holds its last value, so
    // each phase occupies exactly its configured number of cycles.
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_SAT  = CNT_W'(ECHO_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic echo_s;

    sync2 #(
        .WIDTH(1)
    ) u_echo_sync (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (echo),
        .q_o  (echo_s)
    );

    ranging_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] echo_cycles_q, echo_cycles_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            trig_q        <= 1'b0;
            busy_q        <= 1'b0;
            echo_cycles_q <= '0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            trig_q        <= trig_d;
            busy_q        <= busy_d;
            echo_cycles_q <= echo_cycles_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
            count_q       <= count_d;
        end
    end

    // One shared counter times each phase and doubles as the echo width.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        trig_d        = 1'b0;
        echo_cycles_d = echo_cycles_q;
        valid_d       = 1'b0;
        timeout_d     = 1'b0;
        count_d       = count_q;

        unique case (state_q)
            IDLE: begin
                if (start || enable) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                    trig_d  = 1'b1;
                end
            end
            TRIG: begin
                if (cnt_q >= TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_inc;
                    trig_d = 1'b1;
                end
            end
            WAIT_RISE: begin
                if (echo_s) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= RISE_LAST) begin
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    count_d   = count_q + 16'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_d       = HOLDOFF;
                    cnt_d         = '0;
                    echo_cycles_d = cnt_q;
                    valid_d       = 1'b1;
                    count_d       = count_q + 16'd1;
                end else if (cnt_q >= ECHO_LAST) begin
                    state_d       = HOLDOFF;
                    cnt_d         = '0;
                    echo_cycles_d = ECHO_SAT;
                    valid_d       = 1'b1;
                    timeout_d     = 1'b1;
                    count_d       = count_q + 16'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLDOFF: begin
                // A stuck-high echo keeps us here so the next ping starts clean.
                if (cnt_q >= HOLD_LAST && !echo_s) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = TRIG;
                        trig_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign trig         = trig_q;
    assign busy         = busy_q;
    assign echo_cycles  = echo_cycles_q;
    assign meas_valid   = valid_q;
    assign meas_timeout = timeout_q;
    assign meas_count   = count_q;

endmodule
